rr_dispatcher: RTL and testbench
================================

// Module: rr_dispatcher
// PURPOSE
//  Round-robin distributor: one upstream valid/ready message stream fanned out to N downstream lanes.
//  Complement of the N-to-1 grant arbiter: picks a target lane per packet and keeps per-lane credit
//  flow control, so downstream engines never see backpressure. Multi-beat packets stay on one lane.
//  Sits between the order parser and N parallel processing engines.
// PARAMETERS
//  N        3   number of downstream lanes (>=2)
//  DATA_W   64  payload width in bits
//  CREDITS  4   initial and maximum credits per lane (beats each lane can buffer)
// PORTS
//  clk            in   1       single clock, rising edge
//  rst_n          in   1       asynchronous, active-low reset
//  s_valid        in   1       upstream beat valid
//  s_ready        out  1       upstream beat accepted when s_valid & s_ready
//  s_data         in   DATA_W  upstream payload
//  s_last         in   1       final beat of packet
//  m_valid        out  N       one-hot lane strobe, registered
//  m_data         out  DATA_W  shared payload bus, registered
//  m_last         out  1       registered copy of s_last
//  credit_return  in   N       per-lane 1-cycle pulse, returns one credit
//  cred_err       out  1       sticky: credit returned to a full lane
// BEHAVIOUR
//  Reset: m_valid=0, m_data=0, m_last=0, cred_err=0, s_ready=0 while rst_n low;
//   all credit counters=CREDITS; pointer=lane 0 (one-hot 1); state=IDLE. Mid-packet reset discards lock.
//  Eligible[i] = (credit[i] != 0).
//  FSM IDLE: s_ready = |eligible. On accepted beat: lane = first eligible at or above pointer,
//   else lowest eligible (wrap). Pointer <= lane rotated left by one (lane N-1 -> lane 0).
//   If s_last=1 stay IDLE (single-beat packet), else go LOCKED with lane held.
//  FSM LOCKED: s_ready = eligible[lane]; no re-arbitration; beat with s_last accepted -> IDLE.
//   Lane stalls when out of credit; other lanes are never used mid-packet.
//  Output latency 1 cycle: accepted beat in cycle t -> m_valid=onehot(lane), m_data, m_last in t+1.
//   m_valid=0 in any cycle following a non-accepted cycle; m_data/m_last hold their last values.
//  Credits: accept to lane i -> credit[i]-1; credit_return[i] -> +1; both same cycle -> unchanged.
//   Return while credit[i]==CREDITS (and no same-cycle consume) -> counter holds, cred_err <= 1 (sticky until reset).
//   Counter width = $clog2(CREDITS+1); never underflows (s_ready gates consumption).
//  Credit returned in cycle t becomes eligible in t+1 (no combinational credit->ready path).
//  s_ready depends only on registered state; s_valid may toggle freely, data must be held until accepted.
// STRUCTURE
//  Package rr_dispatch_pkg: typedef enum logic {IDLE, LOCKED} disp_state_t; default parameter constants.
//  Sub-module lane_credit_counter (x N): inc/dec/count/nonzero/overflow; CREDITS as parameter.
//  Top holds FSM, pointer, locked-lane register, masked/unmasked lowest-set-bit select, output register.
// TESTING
//  1. N=3, all credits, 6 single-beat msgs back-to-back -> m_valid 001,010,100,001,010,100, each 1 cycle after accept.
//  2. 3-beat packet (last on beat 3) then 1-beat msg -> beats 1-3 on lane 0, next msg on lane 1.
//  3. No credit returns, CREDITS=4: 12 single-beat msgs accepted, 13th sees s_ready=0; pulse credit_return=010 -> next beat to lane 1.
//  4. Lane 1 at 0 credits, pointer at lane 1 -> single-beat msg goes to lane 2; pointer -> lane 0.
//  5. LOCKED on lane 0 with credit 1, 3-beat packet -> beat 2 stalls (s_ready=0) with lanes 1,2 full credit; return on lane 0 and consume same cycle keeps count; packet completes on lane 0.
//  6. credit_return on a full lane -> cred_err=1 and stays 1; assert rst_n low mid-packet -> outputs 0, credits=4, next msg to lane 0.

Source files
------------

// File: rtl/rr_dispatch_pkg.sv
// rtl/rr_dispatch_pkg.sv - shared types and default parameters for the round-robin dispatcher
package rr_dispatch_pkg;

   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} disp_state_t;

   localparam int DEF_N       = 3;
   localparam int DEF_DATA_W  = 64;
   localparam int DEF_CREDITS = 4;

endpackage

// File: rtl/rr_dispatcher_if.sv
// rtl/rr_dispatcher_if.sv - upstream stream, fanned-out lanes and credit return bundle
interface rr_dispatcher_if
   import rr_dispatch_pkg::*;
#(
   parameter int N      = DEF_N,
   parameter int DATA_W = DEF_DATA_W
);
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;
   logic              s_last;
   logic [N-1:0]      m_valid;
   logic [DATA_W-1:0] m_data;
   logic              m_last;
   logic [N-1:0]      credit_return;
   logic              cred_err;

   modport master (
      output s_valid, s_data, s_last, credit_return,
      input  s_ready, m_valid, m_data, m_last, cred_err
   );

   modport slave (
      input  s_valid, s_data, s_last, credit_return,
      output s_ready, m_valid, m_data, m_last, cred_err
   );
endinterface

// File: rtl/lane_credit_counter.sv
// rtl/lane_credit_counter.sv - per-lane credit counter, saturates at CREDITS and flags over-returns
module lane_credit_counter
   import rr_dispatch_pkg::*;
#(
   parameter int  CREDITS = DEF_CREDITS,
   localparam int CW      = $clog2(CREDITS + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inc,
   input  logic          dec,
   output logic [CW-1:0] count,
   output logic          nonzero,
   output logic          overflow
);
   logic [CW-1:0] count_q, count_d;
   logic          full;

   assign full     = (count_q == CW'(CREDITS));
   assign count    = count_q;
   assign nonzero  = (count_q != '0);

   // A return and a consume in the same cycle cancel, even on a full lane.
   always_comb begin
      count_d  = count_q;
      overflow = 1'b0;
      unique case ({inc, dec})
         2'b10: begin
            if (full) overflow = 1'b1;
            else      count_d  = count_q + CW'(1);
         end
         2'b01: begin
            if (nonzero) count_d = count_q - CW'(1);
         end
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count_q <= CW'(CREDITS);
      else        count_q <= count_d;
   end
endmodule

// File: rtl/rr_dispatcher.sv
// rtl/rr_dispatcher.sv - round-robin 1-to-N packet distributor with per-lane credit flow control
module rr_dispatcher
   import rr_dispatch_pkg::*;
#(
   parameter int N       = DEF_N,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int CREDITS = DEF_CREDITS
) (
   input logic           clk,
   input logic           rst_n,
   rr_dispatcher_if.slave bus
);
   localparam int           CW  = $clog2(CREDITS + 1);
   localparam logic [N-1:0] ONE = N'(1);

   function automatic logic [N-1:0] lowest(input logic [N-1:0] x);
      return x & (~x + ONE);
   endfunction

   disp_state_t       state_q, state_d;
   logic [N-1:0]      ptr_q, ptr_d, lane_q, lane_d, mval_q, mval_d;
   logic [N-1:0]      eligible, overflow, masked, pick, lane_sel, consume;
   logic [DATA_W-1:0] mdata_q, mdata_d;
   logic              mlast_q, mlast_d, err_q, err_d, ready, accept;
   logic [CW-1:0]     cnt [N];

   for (genvar i = 0; i < N; i++) begin : g_lane
      lane_credit_counter #(.CREDITS(CREDITS)) u_credit (
         .clk      (clk),
         .rst_n    (rst_n),
         .inc      (bus.credit_return[i]),
         .dec      (consume[i]),
         .count    (cnt[i]),
         .nonzero  (eligible[i]),
         .overflow (overflow[i])
      );
      a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n) cnt[i] <= CW'(CREDITS));
   end

   // Pointer is one-hot: bits at or above it win, otherwise wrap to the lowest eligible lane.
   assign masked = eligible & ~(ptr_q - ONE);
   assign pick   = (|masked) ? lowest(masked) : lowest(eligible);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:   if (accept && !bus.s_last) state_d = LOCKED;
         LOCKED: if (accept &&  bus.s_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ready    = 1'b0;
      lane_sel = lane_q;
      unique case (state_q)
         IDLE: begin
            ready    = |eligible;
            lane_sel = pick;
         end
         LOCKED: begin
            ready    = |(eligible & lane_q);
            lane_sel = lane_q;
         end
         default: ready = 1'b0;
      endcase
      ready = ready & rst_n;
   end

   always_comb begin
      accept  = bus.s_valid & ready;
      consume = accept ? lane_sel : '0;
      ptr_d   = ptr_q;
      lane_d  = lane_q;
      if (accept && (state_q == IDLE)) begin
         ptr_d  = {pick[N-2:0], pick[N-1]};
         lane_d = pick;
      end
      mval_d  = consume;
      mdata_d = accept ? bus.s_data : mdata_q;
      mlast_d = accept ? bus.s_last : mlast_q;
      err_d   = err_q | (|overflow);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q   <= ONE;
         lane_q  <= '0;
         mval_q  <= '0;
         mdata_q <= '0;
         mlast_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         ptr_q   <= ptr_d;
         lane_q  <= lane_d;
         mval_q  <= mval_d;
         mdata_q <= mdata_d;
         mlast_q <= mlast_d;
         err_q   <= err_d;
      end
   end

   assign bus.s_ready  = ready;
   assign bus.m_valid  = mval_q;
   assign bus.m_data   = mdata_q;
   assign bus.m_last   = mlast_q;
   assign bus.cred_err = err_q;
endmodule

// File: tb/tb_rr_dispatcher.sv
// tb/tb_rr_dispatcher.sv - scoreboard bench for rr_dispatcher against a lane/credit reference model
module tb_rr_dispatcher;
   localparam int N  = 3;
   localparam int DW = 64;
   localparam int CR = 4;

   typedef struct {
      int          lane;
      logic [63:0] d;
      logic        l;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   rr_dispatcher_if #(.N(N), .DATA_W(DW)) bus ();
   rr_dispatcher #(.N(N), .DATA_W(DW), .CREDITS(CR)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   exp_t         q[$];
   exp_t         e;
   int           total = 0;
   int           bad   = 0;
   int           mc[N];
   int           mptr, mlane;
   bit           mlocked, merr;
   logic [N-1:0] last_mv;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
      end
   endtask

   // Reference model: credits as integers, pointer as a lane index searched modulo N.
   function automatic bit m_ready();
      if (mlocked) return mc[mlane] > 0;
      for (int i = 0; i < N; i++) if (mc[i] > 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int m_pick();
      for (int k = 0; k < N; k++) if (mc[(mptr + k) % N] > 0) return (mptr + k) % N;
      return -1;
   endfunction

   function automatic void m_reset();
      for (int i = 0; i < N; i++) mc[i] = CR;
      mptr = 0; mlane = 0; mlocked = 0; merr = 0;
   endfunction

   function automatic void m_step(input bit acc, input logic [63:0] d, input bit l, input logic [N-1:0] r);
      int   cons[N];
      int   ln, nc;
      exp_t x;
      for (int i = 0; i < N; i++) cons[i] = 0;
      if (acc) begin
         ln = mlocked ? mlane : m_pick();
         cons[ln] = 1;
         x.lane = ln; x.d = d; x.l = l;
         q.push_back(x);
         if (!mlocked) begin
            mptr = (ln + 1) % N;
            if (!l) begin mlocked = 1; mlane = ln; end
         end else if (l) begin
            mlocked = 0;
         end
      end
      for (int i = 0; i < N; i++) begin
         nc = mc[i] - cons[i] + int'(r[i]);
         if (nc > CR) begin merr = 1; nc = CR; end
         mc[i] = nc;
      end
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("m_valid", 64'(bus.m_valid), 64'd1 << e.lane);
            chk("m_data", bus.m_data, e.d);
            chk("m_last", 64'(bus.m_last), 64'(e.l));
         end else begin
            chk("m_valid_idle", 64'(bus.m_valid), 64'd0);
         end
         if (bus.m_valid != '0) last_mv = bus.m_valid;
      end
   end

   task automatic cycle(input bit v, input logic [63:0] d, input bit l, input logic [N-1:0] r, output bit acc);
      @(negedge clk);
      bus.s_valid = v; bus.s_data = d; bus.s_last = l; bus.credit_return = r;
      #1;
      chk("s_ready", 64'(bus.s_ready), 64'(m_ready()));
      chk("cred_err", 64'(bus.cred_err), 64'(merr));
      acc = v && m_ready();
      m_step(acc, d, l, r);
   endtask

   task automatic idle(input logic [N-1:0] r);
      bit acc;
      cycle(1'b0, 64'd0, 1'b0, r, acc);
   endtask

   task automatic send(input logic [63:0] d, input bit l);
      bit acc;
      int n = 0;
      do begin
         cycle(1'b1, d, l, '0, acc);
         n++;
      end while (!acc && n < 40);
      if (!acc) begin
         total++; bad++;
         $display("FAIL send_timeout actual=not_accepted required=accepted t=%0t", $time);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.credit_return = '0;
      q.delete();
      m_reset();
      last_mv = '0;
      #1;
      chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
      chk("rst_m_data", bus.m_data, 64'd0);
      chk("rst_m_last", 64'(bus.m_last), 64'd0);
      chk("rst_cred_err", 64'(bus.cred_err), 64'd0);
      chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      bit          acc, have;
      logic [63:0] d;
      bit          l;
      logic [N-1:0] r;
      rst_n = 1'b0;
      bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0; bus.credit_return = '0;
      m_reset();
      do_reset();

      // back-to-back single-beat messages rotate 001,010,100,...
      for (int i = 0; i < 6; i++) send(64'h100 + 64'(i), 1'b1);
      idle('0);

      do_reset();
      send(64'hA1, 1'b0); send(64'hA2, 1'b0); send(64'hA3, 1'b1);
      send(64'hB1, 1'b1);
      idle('0);
      chk("pkt_then_msg_lane", 64'(last_mv), 64'b010);

      // exhaust all credits, then a single return on lane 1
      do_reset();
      for (int i = 0; i < 12; i++) send(64'h200 + 64'(i), 1'b1);
      cycle(1'b1, 64'h2FF, 1'b1, '0, acc);
      chk("13th_ready", 64'(bus.s_ready), 64'd0);
      cycle(1'b1, 64'h2FF, 1'b1, 3'b010, acc);
      send(64'h2FF, 1'b1);
      idle('0);
      chk("return_lane1", 64'(last_mv), 64'b010);

      // lane 1 empty while the pointer sits on it
      do_reset();
      send(64'h300, 1'b1);
      for (int i = 0; i < 4; i++) send(64'h310 + 64'(i), i == 3);
      send(64'h320, 1'b1);
      send(64'h321, 1'b1);
      send(64'h330, 1'b1);
      idle('0);
      chk("skip_empty_lane", 64'(last_mv), 64'b100);
      send(64'h331, 1'b1);
      idle('0);
      chk("ptr_wrap_lane0", 64'(last_mv), 64'b001);

      // locked lane stalls with one credit; same-cycle return and consume
      do_reset();
      send(64'h400, 1'b0); send(64'h401, 1'b0); send(64'h402, 1'b1);
      send(64'h410, 1'b1); send(64'h411, 1'b1);
      idle(3'b110);
      send(64'h420, 1'b0);
      cycle(1'b1, 64'h421, 1'b0, '0, acc);
      chk("locked_stall", 64'(bus.s_ready), 64'd0);
      cycle(1'b1, 64'h421, 1'b0, 3'b001, acc);
      chk("ret_not_comb", 64'(acc), 64'd0);
      cycle(1'b1, 64'h421, 1'b0, 3'b001, acc);
      chk("ret_and_consume", 64'(acc), 64'd1);
      send(64'h422, 1'b1);
      idle('0);
      chk("pkt_stays_lane0", 64'(last_mv), 64'b001);

      // over-return sets a sticky error; mid-packet reset drops the lock
      do_reset();
      idle(3'b001);
      idle('0);
      chk("cred_err_set", 64'(bus.cred_err), 64'd1);
      send(64'h500, 1'b1);
      send(64'h501, 1'b0);
      idle('0);
      chk("cred_err_sticky", 64'(bus.cred_err), 64'd1);
      do_reset();
      send(64'h510, 1'b1);
      idle('0);
      chk("post_reset_lane0", 64'(last_mv), 64'b001);

      // randomized traffic with legal credit returns
      do_reset();
      have = 0; d = '0; l = 0;
      for (int c = 0; c < 400; c++) begin
         if (!have) begin
            d    = {$urandom, $urandom};
            l    = ($urandom % 3) == 0;
            have = ($urandom % 4) != 0;
         end
         for (int i = 0; i < N; i++) r[i] = (mc[i] < CR) && (($urandom % 3) == 0);
         cycle(have, d, l, r, acc);
         if (acc) have = 0;
      end
      idle('0);
      idle('0);
      chk("drain", 64'(q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
